// File: rtl/pc_redirect_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pc_redirect_unit
// Brief    : Program counter owner and MEM-stage branch redirect/flush control.
//            Optional branch performance counters are enabled by BRANCH_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pc_redirect_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned MASK_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_write,
    input  logic        Branch_mem,
    input  logic        branch_mem,
    input  logic [31:0] branch_target_mem,
    output logic [31:0] pc_if,
    output logic [31:0] pc_plus4_if,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic        flush_ex_mem,
    output logic        redirect_busy,
    output logic        misalign_err
`ifdef BRANCH_PERF_EN
    ,
    output logic [31:0] perf_branches,
    output logic [31:0] perf_taken
`endif
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SQUASH = 2'd1;

    localparam logic [2:0] c_MASK_INIT = 3'(MASK_CYCLES - 1);

    logic [1:0]  r_state;
    logic [2:0]  r_cnt;
    logic [31:0] r_pc;
    logic        r_misalign;
    logic        w_idle;
    logic        w_take;

    assign w_idle = (r_state == S_IDLE);
    // Gated with rst_n so no flush escapes while reset is held.
    assign w_take = Branch_mem & w_idle & rst_n;

    assign pc_if         = r_pc;
    assign pc_plus4_if   = r_pc + 32'd4;
    assign flush_if_id   = w_take;
    assign flush_id_ex   = w_take;
    assign flush_ex_mem  = w_take;
    assign redirect_busy = (r_state == S_SQUASH) & rst_n;
    assign misalign_err  = r_misalign;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_state    <= S_IDLE;
            r_cnt      <= 3'd0;
            r_misalign <= 1'b0;
        end else begin
            if (w_take) begin
                r_pc <= {branch_target_mem[31:2], 2'b00};
            end else if (pc_write) begin
                r_pc <= r_pc + 32'd4;
            end

            if (w_take && (branch_target_mem[1:0] != 2'b00)) begin
                r_misalign <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_take) begin
                        r_state <= S_SQUASH;
                        r_cnt   <= c_MASK_INIT;
                    end
                end
                S_SQUASH: begin
                    // Counts down independent of stalls so masking never stretches.
                    if (r_cnt == 3'd0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 3'd0;
                end
            endcase
        end
    end

`ifdef BRANCH_PERF_EN
    logic [31:0] r_perf_branches;
    logic [31:0] r_perf_taken;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_perf_branches <= 32'd0;
            r_perf_taken    <= 32'd0;
        end else begin
            if (branch_mem && w_idle) begin
                r_perf_branches <= r_perf_branches + 32'd1;
            end
            if (w_take) begin
                r_perf_taken <= r_perf_taken + 32'd1;
            end
        end
    end

    assign perf_branches = r_perf_branches;
    assign perf_taken    = r_perf_taken;
`else
    // Kept on the interface for stability; only the perf counters consume it.
    logic w_unused_branch_mem;
    assign w_unused_branch_mem = branch_mem;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_redirect_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pc_redirect_unit
// Brief    : Table-driven, scoreboarded testbench for pc_redirect_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_redirect_unit;

    logic        clk;
    logic        rst_n;
    logic        pc_write;
    logic        Branch_mem;
    logic        branch_mem;
    logic [31:0] branch_target_mem;
    logic [31:0] pc_if;
    logic [31:0] pc_plus4_if;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic        flush_ex_mem;
    logic        redirect_busy;
    logic        misalign_err;
`ifdef BRANCH_PERF_EN
    logic [31:0] perf_branches;
    logic [31:0] perf_taken;
`endif

    pc_redirect_unit #(
        .RESET_PC    (32'h0000_0000),
        .MASK_CYCLES (3)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .pc_write          (pc_write),
        .Branch_mem        (Branch_mem),
        .branch_mem        (branch_mem),
        .branch_target_mem (branch_target_mem),
        .pc_if             (pc_if),
        .pc_plus4_if       (pc_plus4_if),
        .flush_if_id       (flush_if_id),
        .flush_id_ex       (flush_id_ex),
        .flush_ex_mem      (flush_ex_mem),
        .redirect_busy     (redirect_busy),
        .misalign_err      (misalign_err)
`ifdef BRANCH_PERF_EN
        ,
        .perf_branches     (perf_branches),
        .perf_taken        (perf_taken)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        pw;
        logic        br;
        logic [31:0] tgt;
        logic [31:0] e_pc;
        logic        e_fl;
        logic        e_busy;
        logic        e_mis;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic        fl;
        logic        busy;
        logic        mis;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   row      = 0;

    function automatic vec_t mk(logic r, logic pw, logic br, logic [31:0] tgt,
                                logic [31:0] e_pc, logic e_fl, logic e_busy, logic e_mis);
        vec_t v;
        v.rst_n = r;  v.pw = pw;  v.br = br;  v.tgt = tgt;
        v.e_pc = e_pc;  v.e_fl = e_fl;  v.e_busy = e_busy;  v.e_mis = e_mis;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    // Drive one cycle of stimulus at negedge, queue its expectation, then
    // compare the settled outputs before the next rising edge.
    task automatic step(vec_t v);
        exp_t e;
        exp_t got;
        @(negedge clk);
        rst_n             = v.rst_n;
        pc_write          = v.pw;
        Branch_mem        = v.br;
        branch_mem        = v.br;
        branch_target_mem = v.tgt;
        e.pc = v.e_pc;  e.fl = v.e_fl;  e.busy = v.e_busy;  e.mis = v.e_mis;
        sb.push_back(e);
        #1;
        got = sb.pop_front();
        check("pc_if",        pc_if,                 got.pc);
        check("pc_plus4_if",  pc_plus4_if,           got.pc + 32'd4);
        check("flush_if_id",  {31'd0, flush_if_id},  {31'd0, got.fl});
        check("flush_id_ex",  {31'd0, flush_id_ex},  {31'd0, got.fl});
        check("flush_ex_mem", {31'd0, flush_ex_mem}, {31'd0, got.fl});
        check("redirect_busy",{31'd0, redirect_busy},{31'd0, got.busy});
        check("misalign_err", {31'd0, misalign_err}, {31'd0, got.mis});
        row++;
    endtask

    initial begin
        rst_n = 1'b0;  pc_write = 1'b0;  Branch_mem = 1'b0;  branch_mem = 1'b0;
        branch_target_mem = 32'h0;
        repeat (2) @(posedge clk);

        //            rst pw br tgt            e_pc           fl busy mis
        tbl.push_back(mk(0, 1, 1, 32'h0000_0100, 32'h0000_0000, 0, 0, 0)); // flush gated in reset
        tbl.push_back(mk(1, 1, 0, 32'h0,         32'h0000_0000, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 32'h0,         32'h0000_0004, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 32'h0,         32'h0000_0008, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 32'h0,         32'h0000_000C, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 32'h0,         32'h0000_0010, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 32'h0,         32'h0000_0014, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 32'h0,         32'h0000_0018, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 32'h0,         32'h0000_001C, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 32'h0000_0100, 32'h0000_0020, 1, 0, 0)); // taken branch
        tbl.push_back(mk(1, 1, 0, 32'h0,         32'h0000_0100, 0, 1, 0));
        tbl.push_back(mk(1, 1, 0, 32'h0,         32'h0000_0104, 0, 1, 0));
        tbl.push_back(mk(1, 1, 0, 32'h0,         32'h0000_0108, 0, 1, 0));
        tbl.push_back(mk(1, 1, 0, 32'h0,         32'h0000_010C, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 32'h0000_0200, 32'h0000_0110, 1, 0, 0)); // held branch
        tbl.push_back(mk(1, 1, 1, 32'h0000_0200, 32'h0000_0200, 0, 1, 0));
        tbl.push_back(mk(1, 1, 1, 32'h0000_0200, 32'h0000_0204, 0, 1, 0));
        tbl.push_back(mk(1, 1, 1, 32'h0000_0200, 32'h0000_0208, 0, 1, 0));
        tbl.push_back(mk(1, 1, 1, 32'h0000_0200, 32'h0000_020C, 1, 0, 0)); // second redirect
        tbl.push_back(mk(1, 0, 0, 32'h0,         32'h0000_0200, 0, 1, 0)); // stall in squash
        tbl.push_back(mk(1, 0, 0, 32'h0,         32'h0000_0200, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 32'h0,         32'h0000_0200, 0, 1, 0));
        tbl.push_back(mk(1, 0, 1, 32'h0000_0040, 32'h0000_0200, 1, 0, 0)); // redirect beats stall
        tbl.push_back(mk(1, 0, 0, 32'h0,         32'h0000_0040, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 32'h0,         32'h0000_0040, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 32'h0,         32'h0000_0040, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 32'h0,         32'h0000_0040, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 32'h0000_0102, 32'h0000_0040, 1, 0, 0)); // misaligned target
        tbl.push_back(mk(1, 1, 0, 32'h0,         32'h0000_0100, 0, 1, 1));
        tbl.push_back(mk(1, 1, 0, 32'h0,         32'h0000_0104, 0, 1, 1));
        tbl.push_back(mk(1, 1, 0, 32'h0,         32'h0000_0108, 0, 1, 1));
        tbl.push_back(mk(1, 1, 1, 32'hFFFF_FFFC, 32'h0000_010C, 1, 0, 1)); // top of space
        tbl.push_back(mk(1, 1, 0, 32'h0,         32'hFFFF_FFFC, 0, 1, 1));
        tbl.push_back(mk(1, 1, 0, 32'h0,         32'h0000_0000, 0, 1, 1)); // wrapped
        tbl.push_back(mk(1, 1, 0, 32'h0,         32'h0000_0004, 0, 1, 1));
        tbl.push_back(mk(1, 1, 0, 32'h0,         32'h0000_0008, 0, 0, 1));

        foreach (tbl[i]) step(tbl[i]);

        // Sticky misalignment across ten more fetch cycles.
        for (int i = 0; i < 10; i++) begin
            step(mk(1, 1, 0, 32'h0, 32'h0000_000C + 32'(4 * i), 0, 0, 1));
        end

        // Reset during the second SQUASH cycle, then an immediate branch.
        step(mk(1, 1, 1, 32'h0000_0300, 32'h0000_0034, 1, 0, 1));
        step(mk(1, 1, 0, 32'h0,         32'h0000_0300, 0, 1, 1));
        step(mk(0, 1, 1, 32'h0000_0400, 32'h0000_0304, 0, 0, 1));
        step(mk(1, 1, 1, 32'h0000_0500, 32'h0000_0000, 1, 0, 0));
`ifdef BRANCH_PERF_EN
        check("perf_branches_after_reset", perf_branches, 32'd0);
        check("perf_taken_after_reset",    perf_taken,    32'd0);
`endif
        step(mk(1, 1, 0, 32'h0,         32'h0000_0500, 0, 1, 0));
`ifdef BRANCH_PERF_EN
        check("perf_branches_one", perf_branches, 32'd1);
        check("perf_taken_one",    perf_taken,    32'd1);
`endif

        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_drain: got %0d expected 0", sb.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_redirect_unit.md
Name: pc_redirect_unit

Overview:
- Owns the program counter and resolves branch redirects for the 5-stage RISC-V pipeline.
- Consumes the MEM-stage branch decision (Branch_mem) and the EX/MEM branch target.
- Drives the IF-stage PC and the flush pulses for IF/ID, ID/EX and EX/MEM.
- Masks the MEM-stage branch decision while squashed bubbles drain.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
MASK_CYCLES, 3, cycles after a redirect during which Branch_mem is ignored (bubbles in MEM); legal range 1..7

Ports:
clk  input  1  pipeline clock, rising edge
rst_n  input  1  synchronous active-low reset
pc_write  input  1  from hazard unit; 0 = stall (hold PC)
Branch_mem  input  1  taken-branch decision from MEM stage
branch_mem  input  1  raw branch-instruction flag in MEM (used by counters)
branch_target_mem  input  32  branch target latched in EX/MEM
pc_if  output  32  current fetch PC (registered)
pc_plus4_if  output  32  pc_if + 4, combinational, mod 2^32
flush_if_id  output  1  clear IF/ID on next edge
flush_id_ex  output  1  clear ID/EX on next edge
flush_ex_mem  output  1  clear EX/MEM on next edge
redirect_busy  output  1  high while in SQUASH
misalign_err  output  1  sticky; target with [1:0] != 0 was taken

Behaviour:
- Reset (rst_n=0 at rising edge):
  - pc_if = RESET_PC, state = IDLE, squash counter = 0, misalign_err = 0.
  - All flush outputs and redirect_busy are 0 while rst_n=0.
  - Reset wins over every other event, including reset mid-SQUASH.
- take = Branch_mem & (state == IDLE). This is combinational.
- flush_if_id = flush_id_ex = flush_ex_mem = take. They are asserted in the same cycle as Branch_mem (zero latency) so the three wrong-path instructions are killed on the next edge.
- PC update, per rising edge, in priority order:
  1. take: pc_if <= {branch_target_mem[31:2], 2'b00}. This overrides pc_write=0 (a redirect beats a stall).
  2. pc_write=1: pc_if <= pc_if + 4. Wraps 32'hFFFF_FFFC -> 32'h0000_0000.
  3. Otherwise: pc_if holds.
- Redirect latency: the target appears on pc_if exactly 1 cycle after Branch_mem.
- FSM:
  - IDLE --take--> SQUASH, with counter <= MASK_CYCLES-1.
  - SQUASH: Branch_mem is ignored, with no flush and no redirect. redirect_busy = 1.
    - counter decrements every cycle regardless of pc_write.
    - counter == 0 -> IDLE on the next edge.
  - SQUASH therefore lasts exactly MASK_CYCLES cycles.
  - Branch_mem in the first IDLE cycle after SQUASH is honoured normally.
- Misalignment: if take and branch_target_mem[1:0] != 0, the redirect still occurs (low bits forced to 0) and misalign_err <= 1. It stays 1 until reset.
- pc_write is sampled only when not taking. A stall in SQUASH holds the PC but does not extend masking.
- No X propagation: all state regs have reset values and the FSM has a default branch back to IDLE.

Optional Feature:
- Macro: BRANCH_PERF_EN.
- When defined:
  - Adds outputs perf_branches[31:0] and perf_taken[31:0], both reset to 0.
  - perf_branches increments each cycle with branch_mem=1 and state==IDLE.
  - perf_taken increments each cycle take=1.
  - Both counters wrap at 2^32, and neither counts during SQUASH.
- When not defined: the ports and counters do not exist. branch_mem is then unused and stays present for interface stability.

Test Plan:
1. Reset sequential fetch: rst_n=0 for 2 cycles, then pc_write=1 for 4 cycles -> pc_if = 0x0, 0x4, 0x8, 0xC, 0x10; flushes stay 0.
2. Taken branch: at pc_if=0x20, pulse Branch_mem=1 with target 0x100 -> all flushes=1 that cycle; next cycle pc_if=0x100, redirect_busy=1 for 3 cycles; then pc_if=0x10C and busy=0.
3. Masking: Branch_mem=1 held for 5 cycles, target 0x200 -> exactly one redirect and one flush pulse; a second redirect fires on cycle 5 (first IDLE cycle after the 3-cycle SQUASH).
4. Stall vs redirect: pc_write=0 with Branch_mem=1, target 0x40 -> pc_if=0x40 next cycle. With pc_write=0 and no branch, pc_if holds for 3 cycles.
5. Misaligned plus wrap: target 0x0000_0102 -> pc_if=0x100 and misalign_err=1, still 1 after 10 cycles. Separately, branch to 0xFFFF_FFFC then pc_write=1 -> pc_if=0x0.
6. Reset mid-SQUASH: assert rst_n=0 during the 2nd SQUASH cycle -> pc_if=RESET_PC and redirect_busy=0. After release, Branch_mem=1 is honoured immediately. With BRANCH_PERF_EN, the counters read 0.
